// File: rtl/auto_seller_pkg.sv
// Shared types and 7-segment codes for the drink vending controller.
// Segment codes are active-low, bit 6 = a ... bit 0 = g.
package auto_seller_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    CHANGE
  } state_e;

  typedef enum logic [1:0] {
    NONE,
    COLA,
    TEA,
    MILK
  } item_e;

  localparam int B_HALF = 0;
  localparam int B_ONE  = 1;
  localparam int B_COLA = 2;
  localparam int B_TEA  = 3;
  localparam int B_MILK = 4;
  localparam int B_ACC  = 5;
  localparam int NBTN   = 6;

  localparam logic [6:0] SEG_0     = 7'h01;
  localparam logic [6:0] SEG_1     = 7'h4F;
  localparam logic [6:0] SEG_2     = 7'h12;
  localparam logic [6:0] SEG_3     = 7'h06;
  localparam logic [6:0] SEG_4     = 7'h4C;
  localparam logic [6:0] SEG_5     = 7'h24;
  localparam logic [6:0] SEG_6     = 7'h20;
  localparam logic [6:0] SEG_7     = 7'h0F;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h04;
  localparam logic [6:0] SEG_C     = 7'h31;
  localparam logic [6:0] SEG_T     = 7'h70;
  localparam logic [6:0] SEG_N     = 7'h6A;
  localparam logic [6:0] SEG_DASH  = 7'h7E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg7_scan.sv
// Four-digit multiplexed display: refresh counter, digit mux, decoder.
// Shows "d.d" from a half-unit value plus an item letter on digit 0.
module seg7_scan
  import auto_seller_pkg::*;
#(
  parameter int REFRESH_DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] val_i,
  input  item_e      item_i,
  output logic [3:0] an_o,
  output logic [6:0] seg_o,
  output logic       dp_o
);

  logic [15:0] div_q, div_d;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic [3:0]  int_dig;

  assign int_dig = 4'(val_i >> 1);

  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    unique case (d)
      4'd0:    digit_seg = SEG_0;
      4'd1:    digit_seg = SEG_1;
      4'd2:    digit_seg = SEG_2;
      4'd3:    digit_seg = SEG_3;
      4'd4:    digit_seg = SEG_4;
      4'd5:    digit_seg = SEG_5;
      4'd6:    digit_seg = SEG_6;
      4'd7:    digit_seg = SEG_7;
      4'd8:    digit_seg = SEG_8;
      4'd9:    digit_seg = SEG_9;
      default: digit_seg = SEG_BLANK;
    endcase
  endfunction

  function automatic logic [6:0] item_seg(input item_e it);
    unique case (it)
      COLA:    item_seg = SEG_C;
      TEA:     item_seg = SEG_T;
      MILK:    item_seg = SEG_N;
      default: item_seg = SEG_DASH;
    endcase
  endfunction

  // Advance the slot counter and build the segments for the current slot.
  always_comb begin
    div_d = div_q + 16'd1;
    idx_d = idx_q;
    if (div_q == 16'(REFRESH_DIV - 1)) begin
      div_d = '0;
      idx_d = idx_q + 2'd1;
    end
    an_d  = ~(4'b0001 << idx_q);
    dp_d  = 1'b1;
    seg_d = SEG_BLANK;
    unique case (idx_q)
      2'd3: begin
        seg_d = digit_seg(int_dig);
        dp_d  = 1'b0;
      end
      2'd2:    seg_d = val_i[0] ? SEG_5 : SEG_0;
      2'd1:    seg_d = SEG_BLANK;
      default: seg_d = item_seg(item_i);
    endcase
  end

  // Digit enable and segments are registered together to avoid ghosting.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      idx_q <= '0;
      an_q  <= 4'b1110;
      seg_q <= SEG_BLANK;
      dp_q  <= 1'b1;
    end else begin
      div_q <= div_d;
      idx_q <= idx_d;
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign an_o  = an_q;
  assign seg_o = seg_q;
  assign dp_o  = dp_q;

endmodule

// File: rtl/auto_seller_top.sv
// Drink vending controller top: button conditioning, sale FSM, display.
// Optional INPUT_DEBOUNCE_EN adds an 8-cycle stability filter per button.
module auto_seller_top
  import auto_seller_pkg::*;
#(
  parameter int PRICE_COLA  = 3,
  parameter int PRICE_TEA   = 4,
  parameter int PRICE_MILK  = 5,
  parameter int MAX_BAL     = 19,
  parameter int REFRESH_DIV = 2,
  parameter int CHANGE_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_half,
  input  logic       coin_one,
  input  logic       sell_cola,
  input  logic       sell_tea,
  input  logic       sell_milk,
  input  logic       account,
  output logic [3:0] an,
  output logic [6:0] a_to_g,
  output logic       DP
);

  logic [NBTN-1:0] btn_raw, sync1_q, sync2_q, ev;

  assign btn_raw = {account, sell_milk, sell_tea,
                    sell_cola, coin_one, coin_half};

  // Two-flop synchroniser for the asynchronous buttons.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

`ifdef INPUT_DEBOUNCE_EN
  logic [NBTN-1:0]      stab_q, stab_d, prev_q;
  logic [NBTN-1:0][2:0] cnt_q, cnt_d;

  // A level change is accepted only after 8 consecutive differing cycles.
  always_comb begin
    stab_d = stab_q;
    cnt_d  = cnt_q;
    for (int i = 0; i < NBTN; i++) begin
      if (sync2_q[i] == stab_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == 3'd7) begin
        stab_d[i] = sync2_q[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 3'd1;
      end
    end
  end

  // Filtered level plus its previous value for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      stab_q <= '0;
      cnt_q  <= '0;
      prev_q <= '0;
    end else begin
      stab_q <= stab_d;
      cnt_q  <= cnt_d;
      prev_q <= stab_q;
    end
  end

  assign ev = stab_q & ~prev_q;
`else
  logic [NBTN-1:0] prev_q;

  // Previous synchronised level for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) prev_q <= '0;
    else     prev_q <= sync2_q;
  end

  assign ev = sync2_q & ~prev_q;
`endif

  state_e      state_q, state_d;
  item_e       item_q, item_d, sel;
  logic [4:0]  bal_q, bal_d;
  logic [4:0]  chg_q, chg_d;
  logic [15:0] hold_q, hold_d;
  logic [1:0]  coin_add;
  logic [5:0]  sum;

  function automatic logic [4:0] price_of(input item_e it);
    unique case (it)
      COLA:    price_of = 5'(PRICE_COLA);
      TEA:     price_of = 5'(PRICE_TEA);
      MILK:    price_of = 5'(PRICE_MILK);
      default: price_of = '0;
    endcase
  endfunction

  // Resolve simultaneous edges: one-unit coin beats half, cola > tea > milk.
  always_comb begin
    coin_add = 2'd0;
    if (ev[B_ONE])       coin_add = 2'd2;
    else if (ev[B_HALF]) coin_add = 2'd1;
    sel = NONE;
    if (ev[B_COLA])      sel = COLA;
    else if (ev[B_TEA])  sel = TEA;
    else if (ev[B_MILK]) sel = MILK;
  end

  assign sum = {1'b0, bal_q} + {4'b0, coin_add};

  // Sale FSM; account outranks every other edge in the same cycle.
  always_comb begin
    state_d = state_q;
    bal_d   = bal_q;
    item_d  = item_q;
    chg_d   = chg_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: begin
        if (!ev[B_ACC] && coin_add != 2'd0 &&
            sum <= 6'(MAX_BAL)) begin
          bal_d   = sum[4:0];
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (ev[B_ACC]) begin
          chg_d   = bal_q - price_of(item_q);
          hold_d  = '0;
          state_d = CHANGE;
        end else if (coin_add != 2'd0) begin
          if (sum <= 6'(MAX_BAL)) bal_d = sum[4:0];
        end else if (sel != NONE &&
                     bal_q >= price_of(sel)) begin
          item_d = sel;
        end
      end
      default: begin
        if (hold_q == 16'(CHANGE_HOLD - 1)) begin
          state_d = IDLE;
          bal_d   = '0;
          item_d  = NONE;
          chg_d   = '0;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 16'd1;
        end
      end
    endcase
  end

  // Sale state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bal_q   <= '0;
      item_q  <= NONE;
      chg_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      bal_q   <= bal_d;
      item_q  <= item_d;
      chg_q   <= chg_d;
      hold_q  <= hold_d;
    end
  end

  logic [4:0] disp_val;

  assign disp_val = (state_q == CHANGE) ? chg_q : bal_q;

  seg7_scan #(
    .REFRESH_DIV(REFRESH_DIV)
  ) u_scan (
    .clk   (clk),
    .rst   (rst),
    .val_i (disp_val),
    .item_i(item_q),
    .an_o  (an),
    .seg_o (a_to_g),
    .dp_o  (DP)
  );

endmodule

// File: tb/tb_auto_seller_top.sv
// Randomised bench for auto_seller_top against a rule-level model.
// Display frames are decoded from an/a_to_g/DP and compared digit by digit.
module tb_auto_seller_top;
  import auto_seller_pkg::*;

  localparam int RD   = 2;
  localparam int HOLD = 100;
  localparam int MAXB = 19;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic coin_half = 0, coin_one = 0;
  logic sell_cola = 0, sell_tea = 0, sell_milk = 0;
  logic account = 0;
  logic [3:0] an;
  logic [6:0] a_to_g;
  logic DP;

  always #5 clk = ~clk;

  auto_seller_top #(
    .REFRESH_DIV(RD),
    .CHANGE_HOLD(HOLD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .coin_half(coin_half),
    .coin_one (coin_one),
    .sell_cola(sell_cola),
    .sell_tea (sell_tea),
    .sell_milk(sell_milk),
    .account  (account),
    .an       (an),
    .a_to_g   (a_to_g),
    .DP       (DP)
  );

  int tests = 0;
  int fails = 0;

  int dig_seg[10] = '{'h01, 'h4F, 'h12, 'h06, 'h4C,
                      'h24, 'h20, 'h0F, 'h00, 'h04};
  int let_seg[4]  = '{'h7E, 'h31, 'h70, 'h6A};
  int price[4]    = '{0, 3, 4, 5};

  int m_bal, m_item, m_chg;
  bit m_chg_on;

  int run_len = 0;
  int change_len = 0;

  // Length of the most recent completed CHANGE interval.
  always @(negedge clk) begin
    if (rst) run_len = 0;
    else if (dut.state_q == CHANGE) run_len++;
    else begin
      if (run_len != 0) change_len = run_len;
      run_len = 0;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int exp_state();
    if (m_chg_on) return int'(CHANGE);
    if (m_bal > 0) return int'(COLLECT);
    return int'(IDLE);
  endfunction

  function automatic void model_reset();
    m_bal = 0;
    m_item = int'(NONE);
    m_chg = 0;
    m_chg_on = 0;
  endfunction

  // Apply the highest-priority button in mask to the model.
  function automatic void model_press(input logic [5:0] mask);
    int ord[6] = '{5, 1, 0, 2, 3, 4};
    int b = -1;
    int v;
    int it;
    for (int i = 0; i < 6; i++)
      if (b < 0 && mask[ord[i]]) b = ord[i];
    if (m_chg_on || b < 0) return;
    case (b)
      5: if (m_bal > 0) begin
        m_chg = m_bal - price[m_item];
        m_chg_on = 1;
      end
      0, 1: begin
        v = (b == 1) ? 2 : 1;
        if (m_bal + v <= MAXB) m_bal += v;
      end
      default: begin
        it = b - 1;
        if (m_bal > 0 && m_bal >= price[it]) m_item = it;
      end
    endcase
  endfunction

  task automatic drive(input logic [5:0] m);
    coin_half = m[0];
    coin_one  = m[1];
    sell_cola = m[2];
    sell_tea  = m[3];
    sell_milk = m[4];
    account   = m[5];
  endtask

  task automatic check_frame(input int val, input int item);
    int seg[4] = '{-1, -1, -1, -1};
    int dp[4]  = '{-1, -1, -1, -1};
    int bad = 0;
    int p;
    for (int i = 0; i < 4 * RD; i++) begin
      @(negedge clk);
      case (an)
        4'b1110: p = 0;
        4'b1101: p = 1;
        4'b1011: p = 2;
        4'b0111: p = 3;
        default: p = -1;
      endcase
      if (p < 0) bad++;
      else begin
        seg[p] = int'(a_to_g);
        dp[p]  = int'(DP);
      end
    end
    chk("an_onehot", bad, 0);
    chk("dig_int", seg[3], dig_seg[val / 2]);
    chk("dig_tenth", seg[2], dig_seg[(val % 2) * 5]);
    chk("dig_blank", seg[1], 'h7F);
    chk("dig_item", seg[0], let_seg[item]);
    chk("dp_on", dp[3], 0);
    chk("dp_off", dp[0] + dp[1] + dp[2], 3);
  endtask

  task automatic do_press(input logic [5:0] m, input int hold);
    if (m[5]) change_len = 0;
    @(negedge clk);
    drive(m);
    repeat (hold) @(negedge clk);
    drive(6'b0);
    repeat (14) @(negedge clk);
    model_press(m);
    chk("bal", int'(dut.bal_q), m_bal);
    chk("item", int'(dut.item_q), m_item);
    chk("state", int'(dut.state_q), exp_state());
    check_frame(m_chg_on ? m_chg : m_bal, m_item);
  endtask

  task automatic settle();
    if (!m_chg_on) return;
    chk("change", int'(dut.chg_q), m_chg);
    for (int i = 0; i < 400 && dut.state_q != IDLE; i++)
      @(negedge clk);
    #1;
    chk("idle", int'(dut.state_q), int'(IDLE));
    chk("hold_len", change_len, HOLD);
    model_reset();
    chk("bal_clr", int'(dut.bal_q), 0);
    chk("item_clr", int'(dut.item_q), int'(NONE));
    check_frame(0, int'(NONE));
  endtask

  initial begin
    logic [5:0] m;
    int r;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_an", int'(an), 'hE);
    chk("rst_seg", int'(a_to_g), 'h7F);
    chk("rst_dp", int'(DP), 1);
    chk("rst_bal", int'(dut.bal_q), 0);
    chk("rst_state", int'(dut.state_q), int'(IDLE));
    rst = 1'b0;

    // Long hold counts once, then full refund.
    do_press(6'b000001, 100);
    do_press(6'b100000, 10);
    settle();

    // Selling and settling with no money.
    do_press(6'b000100, 10);
    do_press(6'b100000, 10);

    // Cola bought with change.
    do_press(6'b000010, 10);
    do_press(6'b000010, 10);
    do_press(6'b000100, 10);
    do_press(6'b100000, 10);
    settle();

    // Milk unaffordable, refund 2.0.
    do_press(6'b000010, 10);
    do_press(6'b000010, 10);
    do_press(6'b010000, 10);
    do_press(6'b100000, 10);
    settle();

    // Balance ceiling.
    for (int i = 0; i < 10; i++) do_press(6'b000010, 9);
    do_press(6'b000001, 9);
    do_press(6'b000010, 9);
    do_press(6'b000001, 9);
    do_press(6'b100000, 9);
    settle();

    // Same-cycle priority.
    do_press(6'b000010, 9);
    do_press(6'b001010, 9);
    do_press(6'b011100, 9);
    do_press(6'b100011, 9);
    settle();

    // Coin ignored during CHANGE, then reset mid-CHANGE.
    do_press(6'b000010, 9);
    do_press(6'b100000, 9);
    do_press(6'b000010, 9);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    model_reset();
    chk("mid_bal", int'(dut.bal_q), 0);
    chk("mid_state", int'(dut.state_q), int'(IDLE));
    chk("mid_an", int'(an), 'hE);
    chk("mid_seg", int'(a_to_g), 'h7F);
    chk("mid_dp", int'(DP), 1);
    rst = 1'b0;

    // Random button traffic.
    for (int n = 0; n < 120; n++) begin
      r = $urandom_range(0, 11);
      if (r <= 3)      m = 6'b000010;
      else if (r <= 6) m = 6'b000001;
      else if (r == 7) m = 6'b000100;
      else if (r == 8) m = 6'b001000;
      else if (r == 9) m = 6'b010000;
      else if (r == 10) m = 6'b100000;
      else m = 6'($urandom_range(1, 63));
      do_press(m, $urandom_range(9, 12));
      settle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
